// File: rtl/pipe_pkg.sv
// Shared defaults and the stage-index type for the in-order pipeline controller.
package pipe_pkg;

    localparam int unsigned NUM_STG_DEF = 5;
    localparam int unsigned W_DEF       = 32;
    localparam int unsigned IDX_W_DEF   = $clog2(NUM_STG_DEF);

    typedef logic [IDX_W_DEF-1:0] stg_idx_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage register: a valid bit plus a W-bit payload.
module pipe_stage_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         kill,
    input  logic         adv,
    input  logic [W-1:0] d_in,
    output logic         valid,
    output logic [W-1:0] d_out
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // Kill wins, then a new token, then an advance leaves a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_in;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign d_out = data_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// N-stage in-order pipeline controller: combinational accept chain with bubble collapse,
// per-stage completion, flush of younger stages and a retirement counter.
module pipe_ctrl_n
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STG = NUM_STG_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned IDX_W   = $clog2(NUM_STG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    input  logic [NUM_STG-1:0]   stg_done,
    input  logic                 flush_req,
    input  logic [IDX_W-1:0]     flush_stg,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic [NUM_STG-1:0]   stg_valid,
    output logic [NUM_STG*W-1:0] stg_data,
    output logic [NUM_STG-1:0]   stg_load,
    output logic [31:0]          retired_cnt
);

    localparam int unsigned L = NUM_STG - 1;

    logic [NUM_STG-1:0] valid;
    logic [NUM_STG-1:0] adv;
    logic [NUM_STG-1:0] acc;
    logic [NUM_STG-1:0] load_raw;
    logic [NUM_STG-1:0] load;
    logic [NUM_STG-1:0] kill;
    int unsigned        flush_idx;
    logic [31:0]        cnt_d, cnt_q;

    // Accept chain runs from the oldest stage down; an empty slot always accepts.
    always_comb begin
        adv    = '0;
        acc    = '0;
        adv[L] = valid[L] & stg_done[L] & out_ready;
        acc[L] = ~valid[L] | adv[L];
        for (int k = NUM_STG - 2; k >= 0; k--) begin
            adv[k] = valid[k] & stg_done[k] & acc[k+1];
            acc[k] = ~valid[k] | adv[k];
        end
    end

    assign in_ready = acc[0] & ~flush_req;
    assign load_raw = {adv[NUM_STG-2:0], in_valid & in_ready};

    always_comb begin
        flush_idx = L;
        if (32'(flush_stg) < NUM_STG) begin
            flush_idx = 32'(flush_stg);
        end
    end

    // Stages below the boundary are emptied; the boundary stage refuses its incoming token.
    always_comb begin
        kill = '0;
        load = '0;
        for (int unsigned k = 0; k < NUM_STG; k++) begin
            kill[k] = flush_req && (k < flush_idx);
            load[k] = load_raw[k] && !(flush_req && (k <= flush_idx));
        end
    end

    for (genvar k = 0; k < NUM_STG; k++) begin : g_slot
        logic [W-1:0] d_in;
        if (k == 0) begin : g_head
            assign d_in = in_data;
        end else begin : g_body
            assign d_in = stg_data[(k-1)*W +: W];
        end
        pipe_stage_slot #(
            .W (W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .kill  (kill[k]),
            .adv   (adv[k]),
            .d_in  (d_in),
            .valid (valid[k]),
            .d_out (stg_data[k*W +: W])
        );
    end

    assign stg_valid = valid;
    assign stg_load  = load & {NUM_STG{rst}};
    assign out_valid = valid[L] & stg_done[L];
    assign out_data  = stg_data[L*W +: W];

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n at the default 5-stage, 32-bit configuration.
module tb_pipe_ctrl_n;
    import pipe_pkg::*;

    localparam int unsigned NS = NUM_STG_DEF;
    localparam int unsigned WD = W_DEF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid;
    logic [WD-1:0]    in_data;
    logic             in_ready;
    logic [NS-1:0]    stg_done;
    logic             flush_req;
    stg_idx_t         flush_stg;
    logic             out_valid;
    logic [WD-1:0]    out_data;
    logic             out_ready;
    logic [NS-1:0]    stg_valid;
    logic [NS*WD-1:0] stg_data;
    logic [NS-1:0]    stg_load;
    logic [31:0]      retired_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_edge;

    pipe_ctrl_n #(
        .NUM_STG (NS),
        .W       (WD),
        .IDX_W   (IDX_W_DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stg_done    (stg_done),
        .flush_req   (flush_req),
        .flush_stg   (flush_stg),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stg_valid   (stg_valid),
        .stg_data    (stg_data),
        .stg_load    (stg_load),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        stg_done  = '0;
        flush_req = 1'b0;
        flush_stg = '0;
        out_ready = 1'b0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", stg_valid, 0);
        chk("rst_data", stg_data, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_inready", in_ready, 1);
        chk("rst_load", stg_load, 0);
        @(negedge clk);
        rst = 1'b1;

        // Streaming 0x1..0x8
        stg_done  = 5'h1F;
        out_ready = 1'b1;
        n_edge    = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_data  = (c < 8) ? 32'(c + 1) : 32'h0;
            #1;
            chk("stream_inready", in_ready, 1);
            chk("stream_ovalid", out_valid, (n_edge >= 5 && n_edge <= 12));
            if (n_edge >= 5 && n_edge <= 12) chk("stream_odata", out_data, n_edge - 4);
            tick();
            n_edge++;
        end
        chk("stream_cnt", retired_cnt, 8);

        // Middle stall on stage 2
        in_valid = 1'b1;
        in_data = 32'h21; tick();
        in_data = 32'h22; tick();
        in_data = 32'h23; tick();
        in_data = 32'h24; tick();
        in_data = 32'h25; tick();
        chk("stall_full_valid", stg_valid, 5'b11111);
        chk("stall_full_data", stg_data, {32'h21, 32'h22, 32'h23, 32'h24, 32'h25});
        stg_done = 5'b11011;
        in_data  = 32'h26;
        #1;
        chk("stall_inready0", in_ready, 0);
        chk("stall_load", stg_load, 5'b10000);
        tick();
        chk("stall_valid_e1", stg_valid, 5'b10111);
        chk("stall_odata_e1", out_data, 32'h22);
        tick();
        chk("stall_valid_e2", stg_valid, 5'b00111);
        tick();
        chk("stall_valid_e3", stg_valid, 5'b00111);
        chk("stall_hold_data", stg_data[95:0], {32'h23, 32'h24, 32'h25});
        chk("stall_inready_e3", in_ready, 0);
        stg_done = 5'h1F;
        #1;
        chk("stall_release_inready", in_ready, 1);
        tick();
        in_data = 32'h27;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_drain_ovalid", out_valid, 1);
            chk("stall_drain_odata", out_data, 32'h23 + i);
            tick();
        end
        chk("stall_empty", stg_valid, 0);
        chk("stall_cnt", retired_cnt, 15);

        // Bubble collapse with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h31; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 32'h32; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 32'h33; tick();
        in_valid = 1'b0;
        chk("bub_start", stg_valid, 5'b10101);
        tick();
        chk("bub_e1", stg_valid, 5'b11010);
        tick();
        chk("bub_e2", stg_valid, 5'b11100);
        chk("bub_order", stg_data[159:64], {32'h31, 32'h32, 32'h33});
        chk("bub_ovalid", out_valid, 1);
        chk("bub_inready", in_ready, 1);

        // Flush at stage 2 with stage 2 advancing
        in_valid = 1'b1; in_data = 32'h34; tick();
        in_data = 32'h35; tick();
        in_valid = 1'b0;
        chk("fl_full", stg_valid, 5'b11111);
        out_ready = 1'b1;
        flush_req = 1'b1;
        flush_stg = 3'd2;
        #1;
        chk("fl_inready", in_ready, 0);
        chk("fl_load", stg_load, 5'b11000);
        tick();
        chk("fl_valid", stg_valid, 5'b11000);
        chk("fl_s3", stg_data[127:96], 32'h33);
        chk("fl_odata", out_data, 32'h32);
        chk("fl_cnt", retired_cnt, 16);

        // Clamped flush colliding with input
        flush_req = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h41; tick();
        chk("cl_fill1", stg_valid, 5'b11001);
        in_data = 32'h42; tick();
        in_data = 32'h43; tick();
        chk("cl_full", stg_valid, 5'b11111);
        flush_req = 1'b1;
        flush_stg = 3'd7;
        in_data   = 32'h44;
        out_ready = 1'b1;
        #1;
        chk("cl_inready", in_ready, 0);
        chk("cl_load", stg_load, 0);
        chk("cl_ovalid", out_valid, 1);
        chk("cl_odata", out_data, 32'h32);
        tick();
        chk("cl_valid", stg_valid, 0);
        chk("cl_cnt", retired_cnt, 17);

        // Counter wrap
        flush_req = 1'b0;
        flush_stg = '0;
        in_valid = 1'b1; in_data = 32'h51; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        #1;
        chk("wrap_ovalid", out_valid, 1);
        chk("wrap_odata", out_data, 32'h51);
        tick();
        chk("wrap_cnt", retired_cnt, 0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'h52 + i;
            tick();
        end
        chk("mid_cnt", retired_cnt, 1);
        chk("mid_valid", stg_valid, 5'b11111);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", stg_valid, 0);
        chk("arst_data", stg_data, 0);
        chk("arst_ovalid", out_valid, 0);
        chk("arst_cnt", retired_cnt, 0);
        chk("arst_load", stg_load, 0);
        chk("arst_inready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
